fetch_queue: RTL and testbench
==============================

// Module: fetch_queue
// PURPOSE
//  Instruction fetch buffer between the fetch stage (PC counter + instruction memory) and decode.
//  - Captures {pc, instr} pairs from fetch in a small circular FIFO.
//  - Presents them in order to decode via a valid/ready handshake.
//  - Discards all buffered entries on a taken branch/jump.
//  - Decouples decode stalls from the fetch PC and replaces the single IF/ID register.
// PARAMETERS
//  DATA_WIDTH  32           width of pc and instr words
//  DEPTH       4            number of FIFO entries; power of 2, >= 2
//  NOP_INSTR   32'h00000013 instruction driven on dec_instr when the queue is empty (addi x0,x0,0)
// PORTS
//  clk           in   1               clock; all state updates on posedge
//  rst           in   1               reset, asynchronous, active-low
//  fetch_valid   in   1               fetch presents a valid {fetch_pc, fetch_instr} this cycle
//  fetch_pc      in   DATA_WIDTH      PC of the fetched instruction
//  fetch_instr   in   DATA_WIDTH      fetched instruction word
//  fetch_ready   out  1               queue can accept a push this cycle (= !full)
//  flush         in   1               taken branch/jump (PCSrcE); empties the queue
//  dec_ready     in   1               decode consumes the head this cycle (= !StallD)
//  dec_valid     out  1               head entry valid (= !empty)
//  dec_pc        out  DATA_WIDTH      PC of head entry
//  dec_instr     out  DATA_WIDTH      instruction of head entry; NOP_INSTR when empty
//  dec_pcplus4   out  DATA_WIDTH      dec_pc + 4, modulo 2^DATA_WIDTH
//  count         out  $clog2(DEPTH+1) number of valid entries, 0..DEPTH
// BEHAVIOUR
//  Reset (rst=0, async):
//  - wr_ptr = rd_ptr = 0, count = 0, dec_valid = 0.
//  - dec_pc = 0, dec_pcplus4 = 4, dec_instr = NOP_INSTR, fetch_ready = 1.
//  - Pushes and pops are ignored while rst = 0.
//  Storage and pointers:
//  - Circular buffer of DEPTH entries.
//  - wr_ptr/rd_ptr are $clog2(DEPTH)+1 bits; the extra MSB distinguishes full from empty.
//  - empty = (wr_ptr == rd_ptr).
//  - full  = index bits equal, MSBs differ.
//  - Pointers wrap modulo 2*DEPTH. Entry index = pointer[$clog2(DEPTH)-1:0].
//  Handshakes:
//  - push = fetch_valid & fetch_ready & !flush.
//  - pop  = dec_valid & dec_ready & !flush.
//  - push writes the entry at wr_ptr and increments wr_ptr at posedge.
//  - pop increments rd_ptr at posedge.
//  Latency:
//  - An entry pushed at edge N is visible on dec_* after edge N (1 cycle).
//  - No combinational fetch->decode bypass.
//  Head outputs:
//  - dec_* are combinational reads of entry rd_ptr.
//  - When empty, dec_instr = NOP_INSTR and dec_pc/dec_pcplus4 hold the last popped values (0/4 after reset).
//  Simultaneous events:
//  - push & pop, not full/not empty: both occur; count unchanged.
//  - Full: fetch_ready = 0 even if dec_ready = 1 (no same-cycle pass-through); the pop proceeds.
//  - Empty: no pop; a push in the same cycle lands and appears next cycle.
//  - flush: rd_ptr <= wr_ptr, count <= 0. Same-cycle push and pop are both suppressed. flush dominates.
//  - flush on an empty queue: no-op; a push that cycle is still dropped.
//  Invariants:
//  - count = wr_ptr - rd_ptr (mod 2*DEPTH), never > DEPTH.
//  - Entries are never reordered or duplicated.
//  - Async reset mid-operation discards all entries immediately.
// TESTING
//  1) Reset: rst=0 for 3 cycles with fetch_valid=1.
//     -> count=0, dec_valid=0, dec_instr=0x00000013, fetch_ready=1; nothing stored after release.
//  2) Fill: dec_ready=0; push pc 0x0,0x4,0x8,0xC.
//     -> count=4, fetch_ready=0; 5th push (pc 0x10) dropped; dec_pc=0x0, dec_pcplus4=0x4.
//  3) Drain: from (2) set dec_ready=1.
//     -> dec_pc 0x0,0x4,0x8,0xC on 4 consecutive cycles, then dec_valid=0, dec_instr=NOP.
//  4) Streaming: fetch_valid=dec_ready=1 for 20 cycles, pc +4 each.
//     -> count stays 1 after the first cycle; pointers wrap; decode sees strictly increasing PCs.
//  5) Flush: 3 entries queued, flush=1 with fetch_valid=1 (pc 0x100).
//     -> next cycle count=0, dec_valid=0; pc 0x100 not stored; next push appears after 1 cycle.
//  6) Async reset mid-stream: drop rst between edges with 2 entries held.
//     -> dec_valid=0 and count=0 immediately, before the next posedge.

Source files
------------

// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : fetch_queue
// Purpose  : Instruction fetch buffer between fetch and decode. Holds
//            {pc, instr} pairs in a small circular FIFO, presents the head to
//            decode over valid/ready, and discards all entries on a taken
//            branch/jump.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_queue #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    DEPTH      = 4,
  parameter logic [DATA_WIDTH-1:0] NOP_INSTR  = 32'h00000013
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         fetch_valid,
  input  logic [DATA_WIDTH-1:0]        fetch_pc,
  input  logic [DATA_WIDTH-1:0]        fetch_instr,
  output logic                         fetch_ready,
  input  logic                         flush,
  input  logic                         dec_ready,
  output logic                         dec_valid,
  output logic [DATA_WIDTH-1:0]        dec_pc,
  output logic [DATA_WIDTH-1:0]        dec_instr,
  output logic [DATA_WIDTH-1:0]        dec_pcplus4,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int PTR_W = IDX_W + 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  // Storage and state
  logic [DATA_WIDTH-1:0] pc_mem_q    [DEPTH];
  logic [DATA_WIDTH-1:0] instr_mem_q [DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [DATA_WIDTH-1:0] last_pc_q, last_pc_d;

  logic [IDX_W-1:0]      w_wr_idx;
  logic [IDX_W-1:0]      w_rd_idx;
  logic [PTR_W-1:0]      w_fill;
  logic                  w_empty;
  logic                  w_full;
  logic                  w_push;
  logic                  w_pop;
  logic [DATA_WIDTH-1:0] w_head_pc;
  logic [DATA_WIDTH-1:0] w_head_instr;

  assign w_wr_idx     = wr_ptr_q[IDX_W-1:0];
  assign w_rd_idx     = rd_ptr_q[IDX_W-1:0];
  assign w_head_pc    = pc_mem_q[w_rd_idx];
  assign w_head_instr = instr_mem_q[w_rd_idx];

  // Extra pointer MSB separates the full case (MSBs differ) from empty.
  assign w_empty = (wr_ptr_q == rd_ptr_q);
  assign w_full  = (w_wr_idx == w_rd_idx) && (wr_ptr_q[IDX_W] != rd_ptr_q[IDX_W]);
  assign w_fill  = wr_ptr_q - rd_ptr_q;

  // A flush suppresses both handshakes; a full queue never passes through.
  assign w_push = fetch_valid && !w_full && !flush;
  assign w_pop  = !w_empty && dec_ready && !flush;

  assign fetch_ready = !w_full;
  assign dec_valid   = !w_empty;
  assign count       = CNT_W'(w_fill);

  // When empty, decode sees a NOP while the PC holds the last popped value.
  assign dec_pc      = w_empty ? last_pc_q : w_head_pc;
  assign dec_instr   = w_empty ? NOP_INSTR : w_head_instr;
  assign dec_pcplus4 = dec_pc + DATA_WIDTH'(4);

  // Next-state for pointers and the remembered last-popped PC.
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    last_pc_d = last_pc_q;
    if (flush) begin
      rd_ptr_d = wr_ptr_q;
    end else begin
      if (w_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (w_pop) begin
        rd_ptr_d  = rd_ptr_q + PTR_W'(1);
        last_pc_d = w_head_pc;
      end
    end
  end

  // Pointer and last-PC registers; async reset discards all entries at once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      last_pc_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      last_pc_q <= last_pc_d;
    end
  end

  // Entry storage; contents need no reset since the pointers gate visibility.
  always_ff @(posedge clk) begin
    if (w_push) begin
      pc_mem_q[w_wr_idx]    <= fetch_pc;
      instr_mem_q[w_wr_idx] <= fetch_instr;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_queue
// Purpose  : Self-checking bench for fetch_queue against a queue-based model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_queue;

  localparam int          DW    = 32;
  localparam int          DEPTH = 4;
  localparam logic [31:0] NOP   = 32'h00000013;

  logic          clk = 1'b0;
  logic          rst;
  logic          fetch_valid;
  logic [DW-1:0] fetch_pc;
  logic [DW-1:0] fetch_instr;
  logic          fetch_ready;
  logic          flush;
  logic          dec_ready;
  logic          dec_valid;
  logic [DW-1:0] dec_pc;
  logic [DW-1:0] dec_instr;
  logic [DW-1:0] dec_pcplus4;
  logic [2:0]    count;

  fetch_queue #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .NOP_INSTR(NOP)) dut (
    .clk(clk), .rst(rst),
    .fetch_valid(fetch_valid), .fetch_pc(fetch_pc), .fetch_instr(fetch_instr),
    .fetch_ready(fetch_ready), .flush(flush), .dec_ready(dec_ready),
    .dec_valid(dec_valid), .dec_pc(dec_pc), .dec_instr(dec_instr),
    .dec_pcplus4(dec_pcplus4), .count(count)
  );

  always #5 clk = ~clk;

  // Reference model: an in-order queue of entries plus the last popped PC.
  typedef struct packed {
    logic [DW-1:0] pc;
    logic [DW-1:0] instr;
  } entry_t;

  entry_t        mq[$];
  logic [DW-1:0] m_last_pc = '0;
  int            n_tests = 0;
  int            n_fail  = 0;

  function automatic logic [DW-1:0] exp_pc();
    return (mq.size() > 0) ? mq[0].pc : m_last_pc;
  endfunction

  function automatic logic [DW-1:0] exp_instr();
    return (mq.size() > 0) ? mq[0].instr : NOP;
  endfunction

  // Advance one clock edge and apply the queue rules to the model.
  task automatic cycle();
    bit do_push, do_pop;
    entry_t e;
    do_push = rst && fetch_valid && (mq.size() < DEPTH) && !flush;
    do_pop  = rst && dec_ready && (mq.size() > 0) && !flush;
    e.pc    = fetch_pc;
    e.instr = fetch_instr;
    @(posedge clk);
    if (!rst) begin
      mq.delete();
      m_last_pc = '0;
    end else if (flush) begin
      mq.delete();
    end else begin
      if (do_pop) begin
        m_last_pc = mq[0].pc;
        void'(mq.pop_front());
      end
      if (do_push) mq.push_back(e);
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; fetch_valid = 1'b1; fetch_pc = 32'h80; fetch_instr = 32'hDEAD_BEEF;
    flush = 1'b0; dec_ready = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) cycle();
    n_tests++; if (count !== 3'd0) begin n_fail++; $display("FAIL reset_count got %0d exp 0", count); end
    n_tests++; if (dec_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b exp 0", dec_valid); end
    n_tests++; if (dec_instr !== NOP) begin n_fail++; $display("FAIL reset_instr got %h exp %h", dec_instr, NOP); end
    n_tests++; if (fetch_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b exp 1", fetch_ready); end
    n_tests++; if (dec_pc !== 32'h0 || dec_pcplus4 !== 32'h4) begin
      n_fail++; $display("FAIL reset_pc got %h/%h exp 0/4", dec_pc, dec_pcplus4); end
    rst = 1'b1; fetch_valid = 1'b0;
    cycle();
    n_tests++; if (count !== 3'd0 || dec_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_release got count %0d valid %b exp 0/0", count, dec_valid); end
  endtask

  task automatic test_fill();
    dec_ready = 1'b0; flush = 1'b0;
    for (int i = 0; i < 5; i++) begin
      fetch_valid = 1'b1; fetch_pc = 32'(i * 4); fetch_instr = $urandom;
      cycle();
    end
    fetch_valid = 1'b0;
    n_tests++; if (count !== 3'd4) begin n_fail++; $display("FAIL fill_count got %0d exp 4", count); end
    n_tests++; if (fetch_ready !== 1'b0) begin n_fail++; $display("FAIL fill_ready got %b exp 0", fetch_ready); end
    n_tests++; if (dec_pc !== 32'h0 || dec_pcplus4 !== 32'h4) begin
      n_fail++; $display("FAIL fill_head got %h/%h exp 0/4", dec_pc, dec_pcplus4); end
    n_tests++; if (dec_instr !== exp_instr()) begin
      n_fail++; $display("FAIL fill_instr got %h exp %h", dec_instr, exp_instr()); end
  endtask

  task automatic test_drain();
    dec_ready = 1'b1; fetch_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      n_tests++; if (dec_valid !== 1'b1 || dec_pc !== 32'(i * 4)) begin
        n_fail++; $display("FAIL drain_pc%0d got %h valid %b exp %h valid 1", i, dec_pc, dec_valid, 32'(i * 4)); end
      cycle();
    end
    n_tests++; if (dec_valid !== 1'b0 || dec_instr !== NOP) begin
      n_fail++; $display("FAIL drain_empty got valid %b instr %h exp 0/%h", dec_valid, dec_instr, NOP); end
    n_tests++; if (dec_pc !== 32'hC || dec_pcplus4 !== 32'h10) begin
      n_fail++; $display("FAIL drain_hold got %h/%h exp c/10", dec_pc, dec_pcplus4); end
  endtask

  task automatic test_streaming();
    logic [DW-1:0] prev;
    prev = '0;
    fetch_valid = 1'b1; dec_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      fetch_pc = 32'h200 + 32'(i * 4); fetch_instr = $urandom;
      cycle();
      n_tests++; if (count !== 3'd1) begin n_fail++; $display("FAIL stream_count%0d got %0d exp 1", i, count); end
      n_tests++; if (dec_pc !== exp_pc() || (i > 0 && dec_pc <= prev)) begin
        n_fail++; $display("FAIL stream_pc%0d got %h exp %h", i, dec_pc, exp_pc()); end
      prev = dec_pc;
    end
    fetch_valid = 1'b0;
    cycle();
    n_tests++; if (dec_valid !== 1'b0) begin n_fail++; $display("FAIL stream_end got valid %b exp 0", dec_valid); end
  endtask

  task automatic test_flush();
    dec_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      fetch_valid = 1'b1; fetch_pc = 32'h40 + 32'(i * 4); fetch_instr = $urandom;
      cycle();
    end
    flush = 1'b1; fetch_pc = 32'h100; fetch_instr = 32'h1234_5678;
    cycle();
    n_tests++; if (count !== 3'd0 || dec_valid !== 1'b0) begin
      n_fail++; $display("FAIL flush_empty got count %0d valid %b exp 0/0", count, dec_valid); end
    n_tests++; if (dec_pc !== exp_pc()) begin n_fail++; $display("FAIL flush_pc got %h exp %h", dec_pc, exp_pc()); end
    flush = 1'b0; fetch_pc = 32'h104; fetch_instr = 32'hCAFE_0001;
    cycle();
    fetch_valid = 1'b0;
    n_tests++; if (count !== 3'd1 || dec_pc !== 32'h104 || dec_instr !== 32'hCAFE_0001) begin
      n_fail++; $display("FAIL flush_next got count %0d pc %h instr %h exp 1/104/cafe0001", count, dec_pc, dec_instr); end
    dec_ready = 1'b1;
    cycle();
    flush = 1'b1; fetch_valid = 1'b1; fetch_pc = 32'h300;
    cycle();
    flush = 1'b0; fetch_valid = 1'b0;
    n_tests++; if (count !== 3'd0 || dec_pc !== 32'h104) begin
      n_fail++; $display("FAIL flush_on_empty got count %0d pc %h exp 0/104", count, dec_pc); end
  endtask

  task automatic test_async_reset();
    dec_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      fetch_valid = 1'b1; fetch_pc = 32'h500 + 32'(i * 4); fetch_instr = $urandom;
      cycle();
    end
    fetch_valid = 1'b0;
    n_tests++; if (count !== 3'd2) begin n_fail++; $display("FAIL arst_pre got %0d exp 2", count); end
    #2 rst = 1'b0;
    #1;
    n_tests++; if (dec_valid !== 1'b0 || count !== 3'd0 || dec_pc !== 32'h0) begin
      n_fail++; $display("FAIL arst_now got valid %b count %0d pc %h exp 0/0/0", dec_valid, count, dec_pc); end
    mq.delete(); m_last_pc = '0;
    @(posedge clk); #1;
    rst = 1'b1;
    cycle();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      fetch_valid = ($urandom_range(0, 3) != 0);
      dec_ready   = ($urandom_range(0, 2) != 0);
      flush       = ($urandom_range(0, 15) == 0);
      fetch_pc    = {$urandom} & 32'hFFFF_FFFC;
      fetch_instr = $urandom;
      cycle();
      n_tests++; if (count !== 3'(mq.size()) || dec_valid !== (mq.size() > 0) || fetch_ready !== (mq.size() < DEPTH)) begin
        n_fail++; $display("FAIL rand_state%0d got count %0d valid %b ready %b exp count %0d", i, count, dec_valid, fetch_ready, mq.size()); end
      n_tests++; if (dec_pc !== exp_pc() || dec_pcplus4 !== exp_pc() + 32'd4 || dec_instr !== exp_instr()) begin
        n_fail++; $display("FAIL rand_head%0d got pc %h pc4 %h instr %h exp %h %h", i, dec_pc, dec_pcplus4, dec_instr, exp_pc(), exp_instr()); end
    end
    flush = 1'b0; fetch_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_fill();
    test_drain();
    test_streaming();
    test_flush();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
